// File: rtl/rmii_pkg.sv
// rmii_pkg: shared RMII receive FSM state encoding and dibit constants
// Contents: rx_state_t (IDLE, PREAMBLE, DATA, DRAIN), PRE_DIBIT, SFD_DIBIT, IDLE_DIBIT
package rmii_pkg;
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DRAIN} rx_state_t;
    localparam logic [1:0] PRE_DIBIT  = 2'b01;
    localparam logic [1:0] SFD_DIBIT  = 2'b11;
    localparam logic [1:0] IDLE_DIBIT = 2'b00;
endpackage

// File: rtl/rmii_rx_framer.sv
// rmii_rx_framer: RMII receive front end, strips preamble/SFD and forwards frame dibits
// Ports: clk_in (50 MHz ref clock), rst_in (async, active-low), crsdv_in/rxd_in (PHY pins),
//        axiov_out/axiod_out (forwarded dibit stream), sof_out (first dibit), eof_out (frame end),
//        err_out (preamble/overlength/alignment error), busy_out (FSM not idle)
module rmii_rx_framer
    import rmii_pkg::*;
#(
    parameter int PREAMBLE_MIN     = 28,
    parameter int MAX_FRAME_DIBITS = 6072
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       crsdv_in,
    input  logic [1:0] rxd_in,
    output logic       axiov_out,
    output logic [1:0] axiod_out,
    output logic       sof_out,
    output logic       eof_out,
    output logic       err_out,
    output logic       busy_out
);
    localparam int CNT_W  = $clog2(MAX_FRAME_DIBITS + 1);
    localparam int PCNT_W = $clog2(PREAMBLE_MIN + 2);
    localparam logic [PCNT_W-1:0] PMAX = PCNT_W'(PREAMBLE_MIN);
    localparam logic [CNT_W-1:0]  DMAX = CNT_W'(MAX_FRAME_DIBITS);

    rx_state_t         state_q, state_d;
    logic [PCNT_W-1:0] pcnt_q, pcnt_d, pre_cnt;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic              axiov_d, sof_d, eof_d, err_d;
    logic [1:0]        axiod_d;

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        dcnt_d  = dcnt_q;
        axiov_d = 1'b0;
        axiod_d = IDLE_DIBIT;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        err_d   = 1'b0;
        // IDLE judges its first carrier dibit with the preamble rules as if pcnt were 0
        pre_cnt = (state_q == IDLE) ? '0 : pcnt_q;
        case (state_q)
            IDLE, PREAMBLE: begin
                if (!crsdv_in) begin
                    state_d = IDLE;
                end else begin
                    state_d = PREAMBLE;
                    pcnt_d  = pre_cnt;
                    if (rxd_in == PRE_DIBIT) begin
                        pcnt_d = (pre_cnt == PMAX) ? pre_cnt : pre_cnt + 1'b1;
                    end else if (rxd_in == SFD_DIBIT && pre_cnt >= PMAX) begin
                        state_d = DATA;
                        dcnt_d  = '0;
                    end else if (!(rxd_in == IDLE_DIBIT && pre_cnt == '0)) begin
                        state_d = DRAIN;
                        err_d   = 1'b1;
                    end
                end
            end
            DATA: begin
                if (!crsdv_in) begin
                    state_d = IDLE;
                    eof_d   = 1'b1;
                    // empty or non-whole-byte frames are flagged alongside eof
                    err_d   = (dcnt_q[1:0] != 2'b00) || (dcnt_q == '0);
                end else if (dcnt_q == DMAX) begin
                    state_d = DRAIN;
                    err_d   = 1'b1;
                end else begin
                    axiov_d = 1'b1;
                    axiod_d = rxd_in;
                    sof_d   = (dcnt_q == '0);
                    dcnt_d  = dcnt_q + 1'b1;
                end
            end
            default: state_d = crsdv_in ? DRAIN : IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q   <= IDLE;
            pcnt_q    <= '0;
            dcnt_q    <= '0;
            axiov_out <= 1'b0;
            axiod_out <= IDLE_DIBIT;
            sof_out   <= 1'b0;
            eof_out   <= 1'b0;
            err_out   <= 1'b0;
            busy_out  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
            axiov_out <= axiov_d;
            axiod_out <= axiod_d;
            sof_out   <= sof_d;
            eof_out   <= eof_d;
            err_out   <= err_d;
            busy_out  <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_rmii_rx_framer.sv
// tb_rmii_rx_framer: checks rmii_rx_framer against a per-carrier-burst frame model
module tb_rmii_rx_framer;
    typedef struct packed {logic c; logic [1:0] d;} cyc_t;
    typedef struct packed {logic v; logic [1:0] d; logic sof; logic eof; logic err; logic busy;} exp_t;
    typedef struct packed {logic c; logic [1:0] d; logic err; logic busy;} vec_t;

    localparam int PMIN = 28;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       crsdv;
    logic [1:0] rxd;
    logic       a_v, a_sof, a_eof, a_err, a_busy;
    logic [1:0] a_d;
    logic       b_v, b_sof, b_eof, b_err, b_busy;
    logic [1:0] b_d;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nva, nea, nvb;
    int ov_s = -1;
    int ov_e = -1;

    cyc_t       st[$];
    exp_t       ea[$];
    exp_t       eb[$];
    logic [1:0] pl[$];
    vec_t       tbl[15];

    always #10 clk = ~clk;

    rmii_rx_framer dut_a (
        .clk_in(clk), .rst_in(rst_n), .crsdv_in(crsdv), .rxd_in(rxd),
        .axiov_out(a_v), .axiod_out(a_d), .sof_out(a_sof), .eof_out(a_eof),
        .err_out(a_err), .busy_out(a_busy)
    );

    rmii_rx_framer #(.MAX_FRAME_DIBITS(64)) dut_b (
        .clk_in(clk), .rst_in(rst_n), .crsdv_in(crsdv), .rxd_in(rxd),
        .axiov_out(b_v), .axiod_out(b_d), .sof_out(b_sof), .eof_out(b_eof),
        .err_out(b_err), .busy_out(b_busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic cmp_a(input exp_t e);
        chk("a_axiov", a_v, e.v);
        chk("a_axiod", a_d, e.d);
        chk("a_sof", a_sof, e.sof);
        chk("a_eof", a_eof, e.eof);
        chk("a_err", a_err, e.err);
        chk("a_busy", a_busy, e.busy);
    endtask

    task automatic cmp_b(input exp_t e);
        chk("b_axiov", b_v, e.v);
        chk("b_axiod", b_d, e.d);
        chk("b_sof", b_sof, e.sof);
        chk("b_eof", b_eof, e.eof);
        chk("b_err", b_err, e.err);
        chk("b_busy", b_busy, e.busy);
    endtask

    task automatic push(input logic c, input logic [1:0] d);
        cyc_t x;
        x.c = c;
        x.d = d;
        st.push_back(x);
    endtask

    task automatic frame(input int lead, input int npre, input bit has_term, input logic [1:0] term, input int gap);
        repeat (lead) push(1'b1, 2'b00);
        repeat (npre) push(1'b1, 2'b01);
        if (has_term) begin
            push(1'b1, term);
            foreach (pl[i]) push(1'b1, pl[i]);
        end
        repeat (gap) push(1'b0, 2'b00);
    endtask

    task automatic load_nominal();
        logic [7:0] nb [22];
        nb = '{8'h69, 8'h69, 8'hA5, 8'h90, 8'h15, 8'h46, 8'h69, 8'h69, 8'hA5, 8'h90, 8'h15,
               8'h06, 8'h01, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34, 8'h56, 8'h78};
        pl.delete();
        foreach (nb[i]) for (int t = 0; t < 4; t++) pl.push_back(nb[i][2*t +: 2]);
    endtask

    task automatic load_random(input int len);
        pl.delete();
        repeat (len) pl.push_back(2'($urandom_range(0, 3)));
    endtask

    // Model: split the stimulus into carrier bursts and decide each burst's fate as a whole.
    // Output index k is what the DUT shows after the edge that sampled input k.
    task automatic build(input int mx, input bit which);
        exp_t q[$];
        int n, k, s, e, i, np, len, fw;
        n = st.size();
        for (int j = 0; j < n; j++) q.push_back('0);
        k = 0;
        while (k < n) begin
            if (!st[k].c) begin
                k++;
            end else begin
                s = k;
                e = k;
                while (e < n && st[e].c) e++;
                for (int j = s; j < e; j++) q[j].busy = 1'b1;
                i = s;
                while (i < e && st[i].d == 2'b00) i++;
                np = 0;
                while (i < e && st[i].d == 2'b01) begin
                    np++;
                    i++;
                end
                if (i < e) begin
                    if (st[i].d == 2'b11 && np >= PMIN) begin
                        len = e - i - 1;
                        fw = (len > mx) ? mx : len;
                        for (int j = 0; j < fw; j++) begin
                            q[i+1+j].v = 1'b1;
                            q[i+1+j].d = st[i+1+j].d;
                        end
                        if (fw > 0) q[i+1].sof = 1'b1;
                        if (len > mx) q[i+1+mx].err = 1'b1;
                        else if (e < n) begin
                            q[e].eof = 1'b1;
                            q[e].err = (len % 4 != 0) || (len == 0);
                        end
                    end else begin
                        q[i].err = 1'b1;
                    end
                end
                k = e;
            end
        end
        if (which) eb = q;
        else ea = q;
    endtask

    task automatic run_stream();
        nva = 0;
        nea = 0;
        nvb = 0;
        build(6072, 1'b0);
        build(64, 1'b1);
        for (int k = 0; k < st.size(); k++) begin
            @(negedge clk);
            crsdv = st[k].c;
            rxd = st[k].d;
            @(posedge clk);
            #1;
            cyc = k;
            cmp_a(ea[k]);
            cmp_b(eb[k]);
            nva += int'(a_v);
            nea += int'(a_err);
            if (k >= ov_s && k < ov_e) nvb += int'(b_v);
        end
    endtask

    initial begin
        int lead, npre, r, len;
        logic [1:0] term;
        rst_n = 1'b0;
        crsdv = 1'b0;
        rxd = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_axiov", a_v, 0);
        chk("rst_axiod", a_d, 0);
        chk("rst_sof", a_sof, 0);
        chk("rst_eof", a_eof, 0);
        chk("rst_err", a_err, 0);
        chk("rst_busy", a_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single-cycle preamble decisions: {crsdv, rxd, expected err, expected busy}
        tbl[0]  = '{c: 1'b0, d: 2'b00, err: 1'b0, busy: 1'b0};
        tbl[1]  = '{c: 1'b1, d: 2'b10, err: 1'b1, busy: 1'b1};
        tbl[2]  = '{c: 1'b1, d: 2'b01, err: 1'b0, busy: 1'b1};
        tbl[3]  = '{c: 1'b0, d: 2'b00, err: 1'b0, busy: 1'b0};
        tbl[4]  = '{c: 1'b1, d: 2'b00, err: 1'b0, busy: 1'b1};
        tbl[5]  = '{c: 1'b1, d: 2'b01, err: 1'b0, busy: 1'b1};
        tbl[6]  = '{c: 1'b1, d: 2'b00, err: 1'b1, busy: 1'b1};
        tbl[7]  = '{c: 1'b0, d: 2'b00, err: 1'b0, busy: 1'b0};
        tbl[8]  = '{c: 1'b1, d: 2'b11, err: 1'b1, busy: 1'b1};
        tbl[9]  = '{c: 1'b0, d: 2'b00, err: 1'b0, busy: 1'b0};
        tbl[10] = '{c: 1'b1, d: 2'b01, err: 1'b0, busy: 1'b1};
        tbl[11] = '{c: 1'b0, d: 2'b01, err: 1'b0, busy: 1'b0};
        tbl[12] = '{c: 1'b1, d: 2'b00, err: 1'b0, busy: 1'b1};
        tbl[13] = '{c: 1'b1, d: 2'b00, err: 1'b0, busy: 1'b1};
        tbl[14] = '{c: 1'b0, d: 2'b00, err: 1'b0, busy: 1'b0};
        foreach (tbl[i]) begin
            @(negedge clk);
            crsdv = tbl[i].c;
            rxd = tbl[i].d;
            @(posedge clk);
            #1;
            cyc = i;
            chk("tbl_axiov", a_v, 0);
            chk("tbl_sof", a_sof, 0);
            chk("tbl_eof", a_eof, 0);
            chk("tbl_err", a_err, tbl[i].err);
            chk("tbl_busy", a_busy, tbl[i].busy);
            chk("tbl_b_err", b_err, tbl[i].err);
        end

        st.delete();
        load_nominal();
        frame(0, 31, 1, 2'b11, 2);
        frame(8, 31, 1, 2'b11, 2);
        frame(0, 10, 1, 2'b11, 3);
        void'(pl.pop_back());
        frame(0, 31, 1, 2'b11, 1);
        load_nominal();
        frame(0, 31, 1, 2'b11, 2);
        frame(0, 28, 1, 2'b11, 2);
        frame(0, 27, 1, 2'b11, 2);
        pl.delete();
        frame(0, 30, 1, 2'b11, 1);
        load_random(100);
        ov_s = st.size();
        frame(0, 30, 1, 2'b11, 2);
        ov_e = st.size();
        load_random(64);
        frame(0, 30, 1, 2'b11, 2);
        load_random(65);
        frame(0, 30, 1, 2'b11, 2);
        for (int f = 0; f < 40; f++) begin
            lead = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            npre = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 27)) : int'($urandom_range(28, 36));
            r = int'($urandom_range(0, 19));
            term = (r == 0) ? 2'b10 : (r == 1) ? 2'b00 : 2'b11;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 90));
            load_random(len);
            frame(lead, npre, $urandom_range(0, 19) != 0, term, int'($urandom_range(1, 3)));
        end
        run_stream();
        chk("overlength_valids", nvb, 64);

        for (int i = 0; i < 31; i++) begin
            @(negedge clk);
            crsdv = 1'b1;
            rxd = 2'b01;
        end
        @(negedge clk);
        rxd = 2'b11;
        load_nominal();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rxd = pl[i];
        end
        @(posedge clk);
        #1;
        chk("pre_reset_axiov", a_v, 1);
        chk("pre_reset_busy", b_busy, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_axiov", a_v, 0);
        chk("async_axiod", a_d, 0);
        chk("async_busy", a_busy, 0);
        chk("async_b_axiov", b_v, 0);
        chk("async_b_busy", b_busy, 0);
        @(negedge clk);
        crsdv = 1'b0;
        rxd = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        st.delete();
        ov_s = -1;
        ov_e = -1;
        load_nominal();
        frame(0, 31, 1, 2'b11, 2);
        run_stream();
        chk("post_reset_valids", nva, 88);
        chk("post_reset_errs", nea, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
